exception_handler: RTL and testbench
====================================

// Module: exception_handler
// PURPOSE
//  Trap controller on the receive side of the memory fault flags (readerror, writeerror, outofboundaccess).
//  Sits after the MEM stage: latches fault cause, faulting PC and bad address; flushes the pipeline and
//  redirects fetch to the handler; on eret, redirects back to the saved PC.
//  A fault taken while already in the handler is a double fault: the core halts until reset.
// PARAMETERS
//  HANDLER_BASE  32'h0000_0040  fetch address of the exception handler
//  RETURN_SKIP   1              1: resume at epc+4 (skip faulting instr); 0: resume at epc (retry)
// PORTS
//  clk               in   1   system clock, rising edge
//  reset             in   1   asynchronous, active-high reset
//  readerror         in   1   misaligned load flag from fault detector (combinational, MEM stage)
//  writeerror        in   1   misaligned store flag from fault detector
//  outofboundaccess  in   1   address outside data memory [0,127]
//  pc_mem            in   32  PC of the instruction currently in MEM
//  addr_mem          in   32  effective address (aluout) of that instruction
//  eret              in   1   return-from-exception, valid while in handler
//  pc_redirect       out  1   fetch must load redirect_target this cycle
//  redirect_target   out  32  new fetch PC, valid when pc_redirect=1
//  flush             out  1   kill all in-flight instructions (IF..MEM), no writeback/store
//  epc               out  32  saved faulting PC
//  badaddr           out  32  saved faulting address
//  cause             out  2   0 none, 1 misaligned load, 2 misaligned store, 3 out of bound
//  in_handler        out  1   handler running; further faults are double faults
//  halted            out  1   double fault seen; sticky until reset
//  exc_count         out  8   exceptions taken (see CONFIGURATION)
// BEHAVIOUR
//  Reset: state=IDLE; every output 0 (epc, badaddr, cause, exc_count all 0).
//  fault = writeerror | readerror | outofboundaccess, sampled at rising clk.
//  Priority if several are set: writeerror(2) > readerror(1) > outofboundaccess(3).
//  States:
//   IDLE:    fault -> TRAP; on that edge latch epc<=pc_mem, badaddr<=addr_mem, cause.
//            eret in IDLE is ignored.
//   TRAP:    1 cycle; flush=1, pc_redirect=1, redirect_target=HANDLER_BASE; flags ignored -> HANDLER.
//   HANDLER: in_handler=1. fault -> HALT (fault wins over simultaneous eret);
//            else eret -> RETURN; else stay.
//   RETURN:  1 cycle; flush=1, pc_redirect=1; redirect_target = epc+4 (RETURN_SKIP=1) or epc
//            (mod 2^32, epc=32'hFFFF_FFFC wraps to 0). Flags ignored. cause<=0 on exit -> IDLE.
//   HALT:    halted=1, flush=1 every cycle, pc_redirect=0; only reset exits.
//  Latency: fault at edge N -> flush/pc_redirect high during cycle N+1. eret at edge M -> redirect during cycle M+1.
//  Outputs are decoded from registered state, so no combinational path from flags to outputs.
//  epc/badaddr/cause are held stable from TRAP through RETURN; they are not overwritten in HANDLER or HALT.
//  Reset asserted mid-TRAP/RETURN: outputs drop to 0 immediately (async) and no redirect is issued.
// CONFIGURATION
//  EXC_COUNT_EN defined: exc_count increments on every IDLE->TRAP transition, saturates at 8'hFF,
//    does not count double faults, cleared only by reset.
//  EXC_COUNT_EN undefined: no counter register; exc_count tied to 8'h00.
// TESTING
//  1 writeerror=1, pc_mem=0x20, addr_mem=0x0D -> next cycle flush=1, redirect_target=0x40; epc=0x20, badaddr=0x0D, cause=2.
//  2 From HANDLER, eret=1 (RETURN_SKIP=1) -> next cycle pc_redirect=1, target=0x24; then IDLE, cause=0, in_handler=0.
//  3 readerror=1 and outofboundaccess=1 together -> cause=1; outofboundaccess only, addr=0x80 -> cause=3.
//  4 In HANDLER, outofboundaccess=1 with eret=1 -> HALT, halted=1, flush held; only reset clears halted.
//  5 Reset pulse during TRAP -> all outputs 0 asynchronously; first fault after reset traps normally.
//  6 EXC_COUNT_EN: 300 trap/eret round trips -> exc_count=0xFF; without the macro, exc_count stays 0.

Source files
------------

// File: rtl/exception_handler.sv
// rtl/exception_handler.sv - memory-fault trap controller (epc/badaddr/cause capture, flush, handler redirect)
// Optional: define EXC_COUNT_EN to enable the saturating exceptions-taken counter on exc_count.
module exception_handler #(
    parameter logic [31:0] HANDLER_BASE = 32'h0000_0040,
    parameter bit          RETURN_SKIP  = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        readerror,
    input  logic        writeerror,
    input  logic        outofboundaccess,
    input  logic [31:0] pc_mem,
    input  logic [31:0] addr_mem,
    input  logic        eret,
    output logic        pc_redirect,
    output logic [31:0] redirect_target,
    output logic        flush,
    output logic [31:0] epc,
    output logic [31:0] badaddr,
    output logic [1:0]  cause,
    output logic        in_handler,
    output logic        halted,
    output logic [7:0]  exc_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_TRAP,
        S_HANDLER,
        S_RETURN,
        S_HALT
    } state_t;

    state_t      state_q;
    logic        flush_q;
    logic        redirect_q;
    logic [31:0] target_q;
    logic [31:0] epc_q;
    logic [31:0] badaddr_q;
    logic [1:0]  cause_q;
    logic        in_handler_q;
    logic        halted_q;

    logic        fault;
    logic [1:0]  fault_cause;
    logic [31:0] ret_target;

    assign fault = writeerror | readerror | outofboundaccess;

    // Store fault outranks load fault, which outranks the bounds check.
    always_comb begin
        fault_cause = 2'd0;
        if (writeerror) begin
            fault_cause = 2'd2;
        end else if (readerror) begin
            fault_cause = 2'd1;
        end else if (outofboundaccess) begin
            fault_cause = 2'd3;
        end
    end

    assign ret_target = RETURN_SKIP ? (epc_q + 32'd4) : epc_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            flush_q      <= 1'b0;
            redirect_q   <= 1'b0;
            target_q     <= 32'd0;
            epc_q        <= 32'd0;
            badaddr_q    <= 32'd0;
            cause_q      <= 2'd0;
            in_handler_q <= 1'b0;
            halted_q     <= 1'b0;
        end else begin
            flush_q      <= 1'b0;
            redirect_q   <= 1'b0;
            target_q     <= 32'd0;
            in_handler_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (fault) begin
                        state_q    <= S_TRAP;
                        epc_q      <= pc_mem;
                        badaddr_q  <= addr_mem;
                        cause_q    <= fault_cause;
                        flush_q    <= 1'b1;
                        redirect_q <= 1'b1;
                        target_q   <= HANDLER_BASE;
                    end
                end
                S_TRAP: begin
                    state_q      <= S_HANDLER;
                    in_handler_q <= 1'b1;
                end
                S_HANDLER: begin
                    if (fault) begin
                        state_q  <= S_HALT;
                        halted_q <= 1'b1;
                        flush_q  <= 1'b1;
                    end else if (eret) begin
                        state_q    <= S_RETURN;
                        flush_q    <= 1'b1;
                        redirect_q <= 1'b1;
                        target_q   <= ret_target;
                    end else begin
                        in_handler_q <= 1'b1;
                    end
                end
                S_RETURN: begin
                    state_q <= S_IDLE;
                    cause_q <= 2'd0;
                end
                S_HALT: begin
                    flush_q <= 1'b1;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

`ifdef EXC_COUNT_EN
    logic [7:0] count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= 8'd0;
        end else if (state_q == S_IDLE && fault && count_q != 8'hFF) begin
            count_q <= count_q + 8'd1;
        end
    end

    assign exc_count = count_q;
`else
    assign exc_count = 8'h00;
`endif

    assign pc_redirect     = redirect_q;
    assign redirect_target = target_q;
    assign flush           = flush_q;
    assign epc             = epc_q;
    assign badaddr         = badaddr_q;
    assign cause           = cause_q;
    assign in_handler      = in_handler_q;
    assign halted          = halted_q;

endmodule

// File: tb/tb_exception_handler.sv
// tb/tb_exception_handler.sv - randomized self-checking bench for exception_handler against a behavioural model
module tb_exception_handler;

    logic        clk = 1'b0;
    logic        reset;
    logic        readerror;
    logic        writeerror;
    logic        outofboundaccess;
    logic [31:0] pc_mem;
    logic [31:0] addr_mem;
    logic        eret;
    logic        pc_redirect;
    logic [31:0] redirect_target;
    logic        flush;
    logic [31:0] epc;
    logic [31:0] badaddr;
    logic [1:0]  cause;
    logic        in_handler;
    logic        halted;
    logic [7:0]  exc_count;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: what the controller is doing this cycle
    bit          m_trap_cycle;
    bit          m_return_cycle;
    bit          m_in_handler;
    bit          m_halted;
    logic [31:0] m_epc;
    logic [31:0] m_badaddr;
    logic [1:0]  m_cause;
    int          m_count;

    exception_handler dut (
        .clk              (clk),
        .reset            (reset),
        .readerror        (readerror),
        .writeerror       (writeerror),
        .outofboundaccess (outofboundaccess),
        .pc_mem           (pc_mem),
        .addr_mem         (addr_mem),
        .eret             (eret),
        .pc_redirect      (pc_redirect),
        .redirect_target  (redirect_target),
        .flush            (flush),
        .epc              (epc),
        .badaddr          (badaddr),
        .cause            (cause),
        .in_handler       (in_handler),
        .halted           (halted),
        .exc_count        (exc_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_trap_cycle   = 0;
        m_return_cycle = 0;
        m_in_handler   = 0;
        m_halted       = 0;
        m_epc          = 32'd0;
        m_badaddr      = 32'd0;
        m_cause        = 2'd0;
        m_count        = 0;
    endtask

    task automatic model_edge();
        bit f;
        f = writeerror | readerror | outofboundaccess;
        if (m_halted) begin
        end else if (m_trap_cycle) begin
            m_trap_cycle = 0;
            m_in_handler = 1;
        end else if (m_return_cycle) begin
            m_return_cycle = 0;
            m_cause        = 2'd0;
        end else if (m_in_handler) begin
            if (f) begin
                m_in_handler = 0;
                m_halted     = 1;
            end else if (eret) begin
                m_in_handler   = 0;
                m_return_cycle = 1;
            end
        end else if (f) begin
            m_trap_cycle = 1;
            m_epc        = pc_mem;
            m_badaddr    = addr_mem;
            m_cause      = writeerror ? 2'd2 : (readerror ? 2'd1 : 2'd3);
            if (m_count < 255) m_count++;
        end
    endtask

    task automatic compare_all(input string tag);
        logic [31:0] exp_target;
        logic [31:0] got_target;
        exp_target = m_trap_cycle ? 32'h40 : (m_return_cycle ? m_epc + 32'd4 : 32'd0);
        got_target = pc_redirect ? redirect_target : 32'd0;
        check({tag, "_redirect"}, 32'(pc_redirect), 32'(m_trap_cycle | m_return_cycle));
        check({tag, "_target"}, got_target, exp_target);
        check({tag, "_flush"}, 32'(flush), 32'(m_trap_cycle | m_return_cycle | m_halted));
        check({tag, "_epc"}, epc, m_epc);
        check({tag, "_badaddr"}, badaddr, m_badaddr);
        check({tag, "_cause"}, 32'(cause), 32'(m_cause));
        check({tag, "_in_handler"}, 32'(in_handler), 32'(m_in_handler));
        check({tag, "_halted"}, 32'(halted), 32'(m_halted));
`ifdef EXC_COUNT_EN
        check({tag, "_count"}, 32'(exc_count), 32'(m_count));
`else
        check({tag, "_count"}, 32'(exc_count), 32'd0);
`endif
    endtask

    task automatic set_in(input bit we, input bit re, input bit oob,
                          input logic [31:0] pc, input logic [31:0] addr, input bit er);
        writeerror       = we;
        readerror        = re;
        outofboundaccess = oob;
        pc_mem           = pc;
        addr_mem         = addr;
        eret             = er;
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        compare_all(tag);
    endtask

    task automatic do_reset(input string tag);
        @(posedge clk);
        #3;
        reset = 1'b1;
        model_reset();
        #1;
        compare_all(tag);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int exp6;
        reset = 1'b1;
        model_reset();
        set_in(0, 0, 0, 32'd0, 32'd0, 0);
        #2;
        compare_all("reset");
        @(negedge clk);
        reset = 1'b0;

        // 1: store fault traps to the handler
        set_in(1, 0, 0, 32'h20, 32'h0D, 0);
        step("t1_trap");
        check("t1_target_abs", redirect_target, 32'h40);
        check("t1_cause_abs", 32'(cause), 32'd2);
        set_in(0, 0, 0, 32'h24, 32'h0, 0);
        step("t1_handler");
        eret = 1'b1;
        // 2: eret resumes past the faulting instruction
        step("t2_return");
        check("t2_target_abs", redirect_target, 32'h24);
        eret = 1'b0;
        step("t2_idle");
        check("t2_cause_abs", 32'(cause), 32'd0);

        // 3: priority between simultaneous flags
        set_in(0, 1, 1, 32'h30, 32'h81, 1);
        step("t3_trap_lo");
        check("t3_cause_ld", 32'(cause), 32'd1);
        set_in(0, 0, 0, 32'h0, 32'h0, 1);
        step("t3_h");
        step("t3_ret");
        eret = 1'b0;
        step("t3_idle");
        set_in(0, 0, 1, 32'h44, 32'h80, 0);
        step("t3_trap_oob");
        check("t3_cause_oob", 32'(cause), 32'd3);

        // 4: fault plus eret inside the handler is a double fault
        set_in(0, 0, 0, 32'h0, 32'h0, 0);
        step("t4_h");
        set_in(0, 0, 1, 32'h99, 32'h1234, 1);
        step("t4_halt");
        check("t4_halted_abs", 32'(halted), 32'd1);
        repeat (4) step("t4_held");
        set_in(0, 0, 0, 32'h0, 32'h0, 1);
        repeat (3) step("t4_held_eret");
        eret = 1'b0;
        do_reset("t4_reset");

        // 5: reset during TRAP suppresses the redirect
        set_in(0, 1, 0, 32'h100, 32'h3, 0);
        step("t5_trap");
        set_in(0, 0, 0, 32'h0, 32'h0, 0);
        do_reset("t5_reset");
        set_in(1, 0, 0, 32'h200, 32'h7, 0);
        step("t5_retrap");
        set_in(0, 0, 0, 32'h0, 32'h0, 0);
        step("t5_h");

        // epc+4 wraps at the top of the address space
        eret = 1'b1;
        step("wrap_ret0");
        eret = 1'b0;
        step("wrap_idle0");
        set_in(0, 0, 1, 32'hFFFF_FFFC, 32'h200, 0);
        step("wrap_trap");
        set_in(0, 0, 0, 32'h0, 32'h0, 1);
        step("wrap_h");
        step("wrap_ret");
        check("wrap_target_abs", redirect_target, 32'h0);
        eret = 1'b0;
        step("wrap_idle");

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            if (m_halted && ($urandom % 8 == 0)) begin
                set_in(0, 0, 0, 32'h0, 32'h0, 0);
                do_reset("rnd_reset");
            end
            set_in(($urandom % 10) == 0, ($urandom % 10) == 0, ($urandom % 10) == 0,
                   $urandom, $urandom, ($urandom % 3) == 0);
            step("rnd");
        end

        // 6: 300 round trips saturate the counter (when present)
        set_in(0, 0, 0, 32'h0, 32'h0, 0);
        do_reset("t6_reset");
        for (int i = 0; i < 300; i++) begin
            set_in(1, 0, 0, 32'(i * 4), 32'(i), 0);
            step("t6_trap");
            set_in(0, 0, 0, 32'h0, 32'h0, 0);
            step("t6_h");
            eret = 1'b1;
            step("t6_ret");
            eret = 1'b0;
            step("t6_idle");
        end
`ifdef EXC_COUNT_EN
        exp6 = 255;
`else
        exp6 = 0;
`endif
        check("t6_count_abs", 32'(exc_count), 32'(exp6));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
